alu_cmd_issuer: RTL

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_pkg.sv | 40 ++++
 rtl/alu_cmd_fifo.sv | 56 +++++
 rtl/alu_cmd_issuer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_pkg.sv
// rtl/alu_cmd_pkg.sv - shared types and constants for the ALU command issuer
//
// Holds the ALU opcode encoding, the issuer FSM state encoding, the data
// values reported on error completions and the packed queue entry layout.
package alu_cmd_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } alu_op_t;

    // Opcodes above this value are rejected without touching the ALU.
    localparam logic [2:0] OP_LAST_LEGAL = OP_XOR;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] ERR_ILLEGAL_DATA = 8'h00;
    localparam logic [7:0] ERR_TIMEOUT_DATA = 8'hFF;

    localparam int CMD_W = 19;

    typedef struct packed {
        logic [2:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command queue for the ALU command issuer
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the queue)
//   push, push_data write request and entry; ignored while full
//   full            no free entry
//   pop             read request; ignored while empty
//   head            oldest entry (valid while not empty)
//   empty           no stored entry
//
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate occupancy counter. DEPTH must be a power of two.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - queues ALU commands, issues them one at a time, returns completions
//
// Optional feature macro: ALU_CMD_ISSUER_TIMEOUT_EN (WAIT timeout with
// out_err=1, out_data=8'hFF after TIMEOUT_CYCLES cycles without res_valid).
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cmd_valid/cmd_ready              upstream command handshake
//   cmd_opcode, cmd_a, cmd_b         command fields
//   alu_valid/alu_ready              ALU issue handshake
//   alu_opcode, alu_a, alu_b         issued command fields
//   res_valid, res_data              ALU result return (only honoured in WAIT)
//   out_valid/out_ready              completion handshake
//   out_data, out_err                completion result and error flag
//   busy                             FSM not IDLE or commands queued
module alu_cmd_issuer
    import alu_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_opcode,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       alu_valid,
    input  logic       alu_ready,
    output logic [2:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic       res_valid,
    input  logic [7:0] res_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_err,
    output logic       busy
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    state_t     state;
    state_t     state_nxt;
    cmd_t       fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       load_issue;
    logic [7:0] out_data_nxt;
    logic       out_err_nxt;
    logic       tmo_hit;

    assign cmd_ready = !fifo_full;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data ({cmd_opcode, cmd_a, cmd_b}),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty)
    );

`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;

    // tmo_cnt holds the number of WAIT cycles already spent, so the last
    // permitted cycle is the one where it reads TIMEOUT_CYCLES-1.
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state != WAIT) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        fifo_pop     = 1'b0;
        load_issue   = 1'b0;
        out_data_nxt = out_data;
        out_err_nxt  = out_err;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (is_legal_op(fifo_head.opcode)) begin
                        load_issue = 1'b1;
                        state_nxt  = ISSUE;
                    end else begin
                        out_data_nxt = ERR_ILLEGAL_DATA;
                        out_err_nxt  = 1'b1;
                        state_nxt    = RESP;
                    end
                end
            end
            ISSUE: begin
                if (alu_valid && alu_ready) state_nxt = WAIT;
            end
            WAIT: begin
                // A result arriving on the expiry cycle takes priority.
                if (res_valid) begin
                    out_data_nxt = res_data;
                    out_err_nxt  = 1'b0;
                    state_nxt    = RESP;
                end else if (tmo_hit) begin
                    out_data_nxt = ERR_TIMEOUT_DATA;
                    out_err_nxt  = 1'b1;
                    state_nxt    = RESP;
                end
            end
            RESP: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            alu_valid  <= 1'b0;
            alu_opcode <= 3'b000;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            out_data   <= 8'h00;
            out_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            // Raised on the second ISSUE cycle (issue registers settled for a
            // full cycle first) and dropped by the handshake leaving ISSUE.
            alu_valid <= (state == ISSUE) && (state_nxt == ISSUE);
            if (load_issue) begin
                alu_opcode <= fifo_head.opcode;
                alu_a      <= fifo_head.a;
                alu_b      <= fifo_head.b;
            end
            out_data <= out_data_nxt;
            out_err  <= out_err_nxt;
        end
    end

    assign out_valid = (state == RESP);
    assign busy      = (state != IDLE) || !fifo_empty;

endmodule
